// File: rtl/delay_event_scheduler.sv
// Timed-event launcher: each accepted (id, delay) request is emitted on the
// evt stream once its delay in clk cycles has elapsed. Optional SCHED_STATS_EN adds counters.
module delay_event_scheduler #(
  parameter int SLOTS   = 4,
  parameter int DELAY_W = 8,
  parameter int ID_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [DELAY_W-1:0] req_delay,
  input  logic [ID_W-1:0]    req_id,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [ID_W-1:0]    evt_id,
  output logic               busy
`ifdef SCHED_STATS_EN
  ,
  output logic [15:0]        fired_count,
  output logic               overflow
`endif
);

  localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  logic [SLOTS-1:0]   r_armed;
  logic [DELAY_W-1:0] r_count [SLOTS];
  logic [ID_W-1:0]    r_id    [SLOTS];
  logic               r_evt_vld_p1;
  logic [ID_W-1:0]    r_evt_id_p1;

  logic               w_free_vld;
  logic [IDX_W-1:0]   w_free_idx;
  logic               w_exp_vld;
  logic [IDX_W-1:0]   w_exp_idx;
  logic               w_load;
  logic               w_accept;
  logic               w_pop;

  function automatic logic [DELAY_W-1:0] dec_sat(input logic [DELAY_W-1:0] v);
    return (v == '0) ? v : v - DELAY_W'(1);
  endfunction

  // Descending scan so the lowest index is the last (winning) assignment.
  always_comb begin
    w_free_vld = 1'b0;
    w_free_idx = '0;
    w_exp_vld  = 1'b0;
    w_exp_idx  = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!r_armed[i]) begin
        w_free_vld = 1'b1;
        w_free_idx = IDX_W'(i);
      end
      if (r_armed[i] && (r_count[i] == '0)) begin
        w_exp_vld = 1'b1;
        w_exp_idx = IDX_W'(i);
      end
    end
  end

  assign w_load   = !r_evt_vld_p1 || evt_ready;
  assign w_accept = req_valid && w_free_vld;
  assign w_pop    = w_load && w_exp_vld;

  // Slot stage: arm on accept, count down, release on launch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_armed <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        r_count[i] <= '0;
        r_id[i]    <= '0;
      end
    end else if (flush) begin
      r_armed <= '0;
      for (int i = 0; i < SLOTS; i++) r_count[i] <= '0;
    end else begin
      for (int i = 0; i < SLOTS; i++) begin
        if (w_pop && (w_exp_idx == IDX_W'(i))) r_armed[i] <= 1'b0;
        else if (r_armed[i])                   r_count[i] <= dec_sat(r_count[i]);
        // The free slot is never the launching one, so these cannot collide.
        if (w_accept && (w_free_idx == IDX_W'(i))) begin
          r_armed[i] <= 1'b1;
          r_count[i] <= req_delay;
          r_id[i]    <= req_id;
        end
      end
    end
  end

  // Output stage: holds the launched event until the consumer takes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_evt_vld_p1 <= 1'b0;
      r_evt_id_p1  <= '0;
    end else if (flush) begin
      r_evt_vld_p1 <= 1'b0;
    end else if (w_load) begin
      r_evt_vld_p1 <= w_exp_vld;
      if (w_exp_vld) r_evt_id_p1 <= r_id[w_exp_idx];
    end
  end

  assign req_ready = w_free_vld;
  assign evt_valid = r_evt_vld_p1;
  assign evt_id    = r_evt_id_p1;
  assign busy      = (|r_armed) || r_evt_vld_p1;

`ifdef SCHED_STATS_EN
  logic [15:0] r_fired;
  logic        r_ovf;

  function automatic logic [15:0] inc_sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fired <= '0;
      r_ovf   <= 1'b0;
    end else if (flush) begin
      r_fired <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (r_evt_vld_p1 && evt_ready) r_fired <= inc_sat16(r_fired);
      if (req_valid && !w_free_vld)  r_ovf   <= 1'b1;
    end
  end

  assign fired_count = r_fired;
  assign overflow    = r_ovf;
`endif

endmodule

// File: tb/tb_delay_event_scheduler.sv
// Scoreboard bench for delay_event_scheduler: directed requests push expected
// (id, accept cycle) entries; a negedge monitor pops and compares each launch.
module tb_delay_event_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_delay = '0;
  logic [3:0] req_id = '0;
  logic       evt_valid;
  logic       evt_ready = 1'b1;
  logic [3:0] evt_id;
  logic       busy;
`ifdef SCHED_STATS_EN
  logic [15:0] fired_count;
  logic        overflow;
`endif

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {int id; int cyc;} exp_t;
  exp_t sb[$];

  logic       stall_vld = 1'b0;
  logic [3:0] stall_id = '0;
  logic       flush_prev = 1'b0;

  delay_event_scheduler #(.SLOTS(4), .DELAY_W(8), .ID_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_delay(req_delay), .req_id(req_id),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
    .busy(busy)
`ifdef SCHED_STATS_EN
    , .fired_count(fired_count), .overflow(overflow)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: launches are checked against the scoreboard, stalls for stability.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stall_vld = 1'b0;
    end else begin
      if (stall_vld && !flush_prev) begin
        n_cmp++;
        if (!evt_valid || evt_id !== stall_id) begin
          n_err++;
          $display("FAIL stall_stable: valid=%0b id=%0d, required valid=1 id=%0d",
                   evt_valid, evt_id, stall_id);
        end
      end
      if (evt_valid && evt_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_evt: id=%0d at cycle %0d, none expected", evt_id, cyc);
        end else begin
          e = sb.pop_front();
          if (int'(evt_id) != e.id || cyc != e.cyc) begin
            n_err++;
            $display("FAIL evt: id=%0d cycle=%0d, required id=%0d cycle=%0d",
                     evt_id, cyc, e.id, e.cyc);
          end
        end
      end
      if (evt_valid && !evt_ready) begin
        stall_vld = 1'b1;
        stall_id  = evt_id;
      end else begin
        stall_vld = 1'b0;
      end
    end
    flush_prev = flush;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic expect_evt(input int id, input int c);
    exp_t e;
    e.id  = id;
    e.cyc = c;
    sb.push_back(e);
  endtask

  // Presents a request until accepted; t returns the accepting edge number.
  task automatic issue(input int id, input int d, output int t);
    bit ok;
    ok = 1'b0;
    req_valid = 1'b1;
    req_id    = 4'(id);
    req_delay = 8'(d);
    t = -1;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL issue_timeout: id=%0d not accepted, required accept within 200 cycles", id);
    end else begin
      t = cyc + 1;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) ok = 1'b1;
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d events outstanding, required 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2, t0, r;

    repeat (3) @(posedge clk);
    #1;
    check("rst_evt_valid", evt_valid, 0);
    check("rst_evt_id", evt_id, 0);
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a countdown discards the event.
    issue(3, 5, t);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_req_ready", req_ready, 1);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_evt_valid", evt_valid, 0);
    repeat (15) @(posedge clk);
    #1;

    // Single requests: D=0 then D=7.
    issue(2, 0, t);
    expect_evt(2, t + 1);
    issue(5, 7, t);
    expect_evt(5, t + 8);
    drain();

    // Fork ordering: both expire together, slot 0 wins.
    issue(1, 2, t);
    issue(2, 1, t2);
    check("fork_back_to_back", t2, t + 1);
    expect_evt(1, t + 3);
    expect_evt(2, t + 4);
    drain();

    // Full: four long requests, fifth waits for a freed slot.
    issue(4, 20, t0);
    issue(5, 20, t);
    issue(6, 20, t);
    issue(7, 20, t);
    expect_evt(4, t0 + 21);
    expect_evt(5, t0 + 22);
    expect_evt(6, t0 + 23);
    expect_evt(7, t0 + 24);
    @(negedge clk);
    check("full_req_ready", req_ready, 0);
    check("full_busy", busy, 1);
    issue(8, 30, t);
    check("full_reuse_edge", t, t0 + 22);
    expect_evt(8, t + 31);
`ifdef SCHED_STATS_EN
    check("full_overflow", overflow, 1);
`endif
    drain();

    // Backpressure with three expired slots, then release.
    evt_ready = 1'b0;
    issue(10, 2, t);
    issue(11, 2, t);
    issue(12, 2, t);
    repeat (10) @(posedge clk);
    #1;
    check("bp_held_id", evt_id, 10);
    check("bp_held_valid", evt_valid, 1);
    r = cyc;
    expect_evt(10, r);
    expect_evt(11, r + 1);
    expect_evt(12, r + 2);
    evt_ready = 1'b1;
    drain();

    // Flush with two armed slots and a held event; concurrent request discarded.
    evt_ready = 1'b0;
    issue(13, 0, t);
    issue(14, 20, t);
    issue(15, 20, t);
    @(negedge clk);
    check("pre_flush_valid", evt_valid, 1);
    check("pre_flush_id", evt_id, 13);
    @(posedge clk);
    #1;
    flush     = 1'b1;
    req_valid = 1'b1;
    req_id    = 4'd9;
    req_delay = 8'd0;
    @(posedge clk);
    #1;
    flush     = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    check("flush_evt_valid", evt_valid, 0);
    check("flush_busy", busy, 0);
    check("flush_req_ready", req_ready, 1);
`ifdef SCHED_STATS_EN
    check("flush_fired_count", fired_count, 0);
    check("flush_overflow", overflow, 0);
`endif
    evt_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("post_flush_busy", busy, 0);
    check("post_flush_sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
